update_hashtb: RTL and testbench

Write-side companion to the connection searcher's hash-table lookup. Accepts insert/delete requests carrying a 5-tuple flow key and a flowKTb index. Hashes the key with the same function the lookup path uses, then does a read-modify-write on the hashTb entry. Sits between the connection manager (flow setup/teardown) and the hashTb RAM write port, and reports a per-request status.

---
 rtl/update_hashtb_if.sv | 36 +++
 rtl/update_hashtb.sv | 173 +++++++++++++++++
 tb/tb_update_hashtb.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/update_hashtb_if.sv
// Request/response and hashTb RAM-port bundle for update_hashtb.
// master = connection manager plus RAM side, slave = update_hashtb.
interface update_hashtb_if #(
    parameter int W_KEY    = 104,
    parameter int W_HASHTB = 17,
    parameter int D_HASHTB = 10,
    parameter int W_IDX    = 16
);
    logic                upd_valid;
    logic                upd_ready;
    logic                upd_op;
    logic [W_KEY-1:0]    upd_key;
    logic [W_IDX-1:0]    upd_idx;

    logic                rden_hashTb;
    logic [D_HASHTB-1:0] rdAddr_hashTb;
    logic [W_HASHTB-1:0] ctx_hashTb;
    logic                wren_hashTb;
    logic [D_HASHTB-1:0] wrAddr_hashTb;
    logic [W_HASHTB-1:0] data_hashTb;

    logic                resp_valid;
    logic [1:0]          resp_status;

    modport master (
        output upd_valid, upd_op, upd_key, upd_idx, ctx_hashTb,
        input  upd_ready, rden_hashTb, rdAddr_hashTb, wren_hashTb,
               wrAddr_hashTb, data_hashTb, resp_valid, resp_status
    );

    modport slave (
        input  upd_valid, upd_op, upd_key, upd_idx, ctx_hashTb,
        output upd_ready, rden_hashTb, rdAddr_hashTb, wren_hashTb,
               wrAddr_hashTb, data_hashTb, resp_valid, resp_status
    );
endinterface

// File: rtl/update_hashtb.sv
// Insert/delete engine for the connection searcher's hashTb: hash, read, check, write.
// Optional macro HASHTB_DEL_CHECK_EN: delete clears an entry only when its stored idx matches.
module update_hashtb #(
    parameter int W_KEY          = 104,
    parameter int W_HASHTB       = 17,
    parameter int D_HASHTB       = 10,
    parameter int W_IDX          = 16,
    parameter int B_SRCIP_KEY    = 0,
    parameter int B_DSTIP_KEY    = 32,
    parameter int B_SRCPORT_KEY  = 64,
    parameter int B_DSTPORT_KEY  = 80,
    parameter int B_VALID_HASHTB = 16,
    parameter int RD_LAT         = 2
) (
    input  logic           clk,
    input  logic           reset,
    update_hashtb_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_CHK,
        S_WR
    } state_t;

    typedef enum logic [1:0] {
        ST_OK        = 2'b00,
        ST_OCCUPIED  = 2'b01,
        ST_NOT_FOUND = 2'b10,
        ST_IDX_ERR   = 2'b11
    } status_t;

    localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                op_q, op_d;
    logic [W_IDX-1:0]    idx_q, idx_d;
    logic [D_HASHTB-1:0] hash_q, hash_d;
    logic                do_wr_q, do_wr_d;
    logic [D_HASHTB-1:0] wr_addr_q, wr_addr_d;
    logic [W_HASHTB-1:0] wr_data_q, wr_data_d;
    status_t             status_q, status_d;

    logic [D_HASHTB-1:0] key_hash;
    logic                entry_valid;
    logic                chk_wr;
    logic [W_HASHTB-1:0] chk_data;
    status_t             chk_status;

    // Must match the lookup path bit for bit; protocol is deliberately excluded.
    always_comb begin
        key_hash = bus.upd_key[B_SRCIP_KEY   +: D_HASHTB]
                 ^ bus.upd_key[B_DSTIP_KEY   +: D_HASHTB]
                 ^ bus.upd_key[B_SRCPORT_KEY +: D_HASHTB]
                 ^ bus.upd_key[B_DSTPORT_KEY +: D_HASHTB];
    end

    assign entry_valid = bus.ctx_hashTb[B_VALID_HASHTB];

    // Decision on the entry returned by the RAM; only meaningful while in S_CHK.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        chk_wr     = 1'b0;
        chk_data   = '0;
        chk_status = ST_OK;
        if (!op_q) begin
            if (idx_q == '0) begin
                chk_status = ST_IDX_ERR;
            end else if (entry_valid) begin
                chk_status = ST_OCCUPIED;
            end else begin
                chk_wr                   = 1'b1;
                chk_data[B_VALID_HASHTB] = 1'b1;
                chk_data[W_IDX-1:0]      = idx_q;
            end
        end else begin
            if (!entry_valid) begin
                chk_status = ST_NOT_FOUND;
`ifdef HASHTB_DEL_CHECK_EN
            end else if (bus.ctx_hashTb[W_IDX-1:0] != idx_q) begin
                chk_status = ST_IDX_ERR;
`endif
            end else begin
                chk_wr = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            op_q       <= 1'b0;
            idx_q      <= '0;
            hash_q     <= '0;
            do_wr_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            status_q   <= ST_OK;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            hash_q     <= hash_d;
            do_wr_q    <= do_wr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            status_q   <= status_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        op_d       = op_q;
        idx_d      = idx_q;
        hash_d     = hash_q;
        do_wr_d    = do_wr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        status_d   = status_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.upd_valid) begin
                    op_d    = bus.upd_op;
                    idx_d   = bus.upd_idx;
                    hash_d  = key_hash;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                wait_cnt_d = WAIT_INIT;
                state_d    = (RD_LAT == 1) ? S_CHK : S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt_q == '0) state_d = S_CHK;
                else                  wait_cnt_d = wait_cnt_q - 1'b1;
            end
            S_CHK: begin
                do_wr_d  = chk_wr;
                status_d = chk_status;
                // Write address/data only move when a write is issued, so they hold otherwise.
                if (chk_wr) begin
                    wr_addr_d = hash_q;
                    wr_data_d = chk_data;
                end
                state_d = S_WR;
            end
            S_WR: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.upd_ready     = (state_q == S_IDLE);
        bus.rden_hashTb   = (state_q == S_RD);
        bus.rdAddr_hashTb = hash_q;
        bus.wren_hashTb   = (state_q == S_WR) && do_wr_q;
        bus.wrAddr_hashTb = wr_addr_q;
        bus.data_hashTb   = wr_data_q;
        bus.resp_valid    = (state_q == S_WR);
        bus.resp_status   = status_q;
    end

endmodule

// File: tb/tb_update_hashtb.sv
// Self-checking bench for update_hashtb: directed scenarios then random insert/delete
// traffic against a table model, with a behavioural hashTb RAM of read latency RD_LAT.
module tb_update_hashtb;

    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    update_hashtb_if bus ();

    update_hashtb #(.RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural hashTb RAM: read data appears RD_LAT cycles after the read strobe.
    logic [16:0] mem [1024] = '{default: '0};
    logic [16:0] rd_pipe [RD_LAT] = '{default: '0};

    always @(posedge clk) begin
        if (bus.wren_hashTb) mem[bus.wrAddr_hashTb] <= bus.data_hashTb;
        if (bus.rden_hashTb) rd_pipe[0] <= mem[bus.rdAddr_hashTb];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.ctx_hashTb = rd_pipe[RD_LAT-1];

    // Reference table, kept as separate valid/idx arrays.
    logic        ref_valid [1024] = '{default: 1'b0};
    logic [15:0] ref_idx   [1024] = '{default: '0};

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [16:0] last_data = '0;
    logic [9:0]  last_wr_addr = '0;

    task automatic check(input string tag, input string what,
                         input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s.%s: observed 0x%0h expected 0x%0h", tag, what, obs, exp);
        end
    endtask

    function automatic logic [103:0] mk_key(input logic [31:0] sip, input logic [31:0] dip,
                                            input logic [15:0] sp, input logic [15:0] dp,
                                            input logic [7:0] proto);
        return {proto, dp, sp, dip, sip};
    endfunction

    function automatic logic [9:0] hash_of(input logic [103:0] k);
        int unsigned s;
        s = k[31:0] ^ k[63:32] ^ 32'(k[79:64]) ^ 32'(k[95:80]);
        return 10'(s % 1024);
    endfunction

    task automatic predict(input logic op, input logic [9:0] h, input logic [15:0] idx,
                           output logic [1:0] st, output logic wr, output logic [16:0] d);
        wr = 1'b0;
        d  = '0;
        st = 2'd0;
        if (!op) begin
            if (idx == 16'd0)      st = 2'd3;
            else if (ref_valid[h]) st = 2'd1;
            else begin
                wr = 1'b1;
                d  = {1'b1, idx};
                ref_valid[h] = 1'b1;
                ref_idx[h]   = idx;
            end
        end else begin
            if (!ref_valid[h]) st = 2'd2;
`ifdef HASHTB_DEL_CHECK_EN
            else if (ref_idx[h] != idx) st = 2'd3;
`endif
            else begin
                wr = 1'b1;
                ref_valid[h] = 1'b0;
                ref_idx[h]   = '0;
            end
        end
    endtask

    task automatic run_req(input string tag, input logic op,
                           input logic [103:0] key, input logic [15:0] idx);
        logic [9:0]  h;
        logic [1:0]  st;
        logic        wr;
        logic [16:0] d;
        h = hash_of(key);
        predict(op, h, idx, st, wr, d);
        @(negedge clk);
        check(tag, "ready_idle", 32'(bus.upd_ready), 32'd1);
        bus.upd_valid = 1'b1;
        bus.upd_op    = op;
        bus.upd_key   = key;
        bus.upd_idx   = idx;
        @(posedge clk);
        for (int c = 1; c <= 3 + RD_LAT; c++) begin
            @(negedge clk);
            // Requests offered while busy must be ignored.
            if (c <= 1 + RD_LAT) begin
                bus.upd_valid = 1'b1;
                bus.upd_op    = 1'($urandom_range(0, 1));
                bus.upd_key   = {$urandom(), $urandom(), $urandom(), 8'($urandom())};
                bus.upd_idx   = 16'($urandom());
            end else begin
                bus.upd_valid = 1'b0;
            end
            check(tag, $sformatf("rden_c%0d", c), 32'(bus.rden_hashTb), 32'(c == 1));
            if (c == 1) check(tag, "rdaddr", 32'(bus.rdAddr_hashTb), 32'(h));
            check(tag, $sformatf("ready_c%0d", c), 32'(bus.upd_ready), 32'(c == 3 + RD_LAT));
            check(tag, $sformatf("resp_c%0d", c), 32'(bus.resp_valid), 32'(c == 2 + RD_LAT));
            check(tag, $sformatf("wren_c%0d", c), 32'(bus.wren_hashTb),
                  32'((c == 2 + RD_LAT) && wr));
            if (c == 2 + RD_LAT) begin
                check(tag, "status", 32'(bus.resp_status), 32'(st));
                check(tag, "wrdata", 32'(bus.data_hashTb), 32'(wr ? d : last_data));
                check(tag, "wraddr", 32'(bus.wrAddr_hashTb), 32'(wr ? h : last_wr_addr));
            end
        end
        if (wr) begin
            last_data    = d;
            last_wr_addr = h;
        end
        check(tag, "entry", 32'(mem[h]), 32'({ref_valid[h], ref_idx[h]}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [103:0] k_a, k_b, k_c, k_d, k_e;
        logic [103:0] pool [5];
        logic [9:0]   h;

        k_a = mk_key(32'h0A000001, 32'h0A000002, 16'h1234, 16'h0050, 8'h06);
        k_b = mk_key(32'h00000267, 32'h0, 16'h0, 16'h0, 8'h11);
        k_c = mk_key(32'hC0A80101, 32'hC0A80202, 16'd443, 16'd5000, 8'h06);
        k_d = mk_key(32'h00000230, 32'h0, 16'h0, 16'h0, 8'h11);
        k_e = mk_key(32'hDEADBEEF, 32'h12345678, 16'hAAAA, 16'h5555, 8'h06);
        pool = '{k_a, k_b, k_c, k_d, k_e};

        reset         = 1'b1;
        bus.upd_valid = 1'b0;
        bus.upd_op    = 1'b0;
        bus.upd_key   = '0;
        bus.upd_idx   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset", "ready", 32'(bus.upd_ready), 32'd1);
        check("reset", "rden", 32'(bus.rden_hashTb), 32'd0);
        check("reset", "rdaddr", 32'(bus.rdAddr_hashTb), 32'd0);
        check("reset", "wren", 32'(bus.wren_hashTb), 32'd0);
        check("reset", "wraddr", 32'(bus.wrAddr_hashTb), 32'd0);
        check("reset", "data", 32'(bus.data_hashTb), 32'd0);
        check("reset", "resp", 32'(bus.resp_valid), 32'd0);
        check("reset", "status", 32'(bus.resp_status), 32'd0);
        reset = 1'b0;

        run_req("ins_a5", 1'b0, k_a, 16'h0005);
        check("ins_a5", "mem_267", 32'(mem[10'h267]), 32'h10005);
        run_req("ins_a9_occupied", 1'b0, k_a, 16'h0009);
        run_req("ins_b0_idxerr", 1'b0, k_b, 16'h0000);
        run_req("del_a9", 1'b1, k_a, 16'h0009);
`ifndef HASHTB_DEL_CHECK_EN
        run_req("reins_a5", 1'b0, k_a, 16'h0005);
`endif
        run_req("del_a5", 1'b1, k_a, 16'h0005);
        run_req("del_a5_again", 1'b1, k_a, 16'h0005);

        // Reset lands in cycle 3 (CHK) of an insert: the request must vanish without trace.
        h = hash_of(k_c);
        @(negedge clk);
        bus.upd_valid = 1'b1;
        bus.upd_op    = 1'b0;
        bus.upd_key   = k_c;
        bus.upd_idx   = 16'h0007;
        @(posedge clk);
        @(negedge clk);
        bus.upd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort", "ready", 32'(bus.upd_ready), 32'd1);
        check("abort", "wren_c3", 32'(bus.wren_hashTb), 32'd0);
        check("abort", "resp_c3", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        check("abort", "wren_c4", 32'(bus.wren_hashTb), 32'd0);
        check("abort", "resp_c4", 32'(bus.resp_valid), 32'd0);
        check("abort", "data", 32'(bus.data_hashTb), 32'd0);
        check("abort", "wraddr", 32'(bus.wrAddr_hashTb), 32'd0);
        reset        = 1'b0;
        last_data    = '0;
        last_wr_addr = '0;
        @(negedge clk);
        check("abort", "no_write", 32'(mem[h]), 32'({ref_valid[h], ref_idx[h]}));
        run_req("after_abort", 1'b0, k_c, 16'h0007);

        for (int n = 0; n < 40; n++) begin
            logic        op;
            logic [15:0] idx;
            op  = 1'($urandom_range(0, 1));
            idx = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom_range(1, 6));
            run_req($sformatf("rnd%0d", n), op, pool[$urandom_range(0, 4)], idx);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
